arf054b128e1r1w0cbbehraa4acw_bist_addr_seq: RTL and testbench



---
 rtl/arf054b128e1r1w0cbbehraa4acw_bist_pkg.sv | 15 +
 rtl/arf054b128e1r1w0cbbehraa4acw_bist_decoder.sv | 19 +
 rtl/arf054b128e1r1w0cbbehraa4acw_bist_addr_seq.sv | 151 +++++++++++++++
 tb/tb_arf054b128e1r1w0cbbehraa4acw_bist_addr_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_pkg.sv
// Shared types for the register-file BIST address sequencer: FSM states and
// march direction encoding.
package arf054b128e1r1w0cbbehraa4acw_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_t;

   // Direction of a march element as presented on the dir input.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_decoder.sv
// Binary-to-one-hot decoder. Output lines above the highest reachable code
// simply never fire, so non-power-of-two depths need no special casing.
module arf054b128e1r1w0cbbehraa4acw_bist_decoder #(
   parameter int IN_WIDTH  = 7,
   parameter int OUT_WIDTH = 128
) (
   input  logic [IN_WIDTH-1:0]  code,
   output logic [OUT_WIDTH-1:0] onehot
);

   // One comparator per output line.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_dec
         assign onehot[gi] = (code == IN_WIDTH'(gi));
      end
   endgenerate

endmodule

// File: rtl/arf054b128e1r1w0cbbehraa4acw_bist_addr_seq.sv
// BIST address sequencer: walks all DEPTH entries of the array in one march
// element (ascending or descending), repeating each address num_ops+1 times,
// with stall (adv=0) and abort. Every output is a flop, computed from the
// next-state values so addr, sel and the flags line up in the same cycle.
module arf054b128e1r1w0cbbehraa4acw_bist_addr_seq
   import arf054b128e1r1w0cbbehraa4acw_bist_pkg::*;
#(
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int OPS_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  dir,
   input  logic [OPS_WIDTH-1:0]  num_ops,
   input  logic                  adv,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DEPTH-1:0]      sel,
   output logic [OPS_WIDTH-1:0]  op_idx,
   output logic                  first_addr,
   output logic                  last_addr,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LO = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_HI = ADDR_WIDTH'(DEPTH - 1);

   bist_state_t           state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [OPS_WIDTH-1:0]  op_idx_reg, op_idx_next;
   logic                  dir_reg, dir_next;
   logic [OPS_WIDTH-1:0]  num_ops_reg, num_ops_next;

   logic [DEPTH-1:0]      sel_reg, sel_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;
   logic                  first_reg, first_next;
   logic                  last_reg, last_next;

   logic [DEPTH-1:0]      dec_onehot;
   logic [ADDR_WIDTH-1:0] end_addr;
   logic [ADDR_WIDTH-1:0] first_code, last_code;

   // Decode the address that will be presented next cycle, so sel lands
   // together with addr.
   arf054b128e1r1w0cbbehraa4acw_bist_decoder #(
      .IN_WIDTH  (ADDR_WIDTH),
      .OUT_WIDTH (DEPTH)
   ) u_decoder (
      .code   (addr_next),
      .onehot (dec_onehot)
   );

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         addr_reg    <= '0;
         op_idx_reg  <= '0;
         dir_reg     <= DIR_UP;
         num_ops_reg <= '0;
         sel_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         first_reg   <= 1'b0;
         last_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         op_idx_reg  <= op_idx_next;
         dir_reg     <= dir_next;
         num_ops_reg <= num_ops_next;
         sel_reg     <= sel_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         first_reg   <= first_next;
         last_reg    <= last_next;
      end
   end

   // Final address of the running element depends on the latched direction.
   assign end_addr = (dir_reg == DIR_DOWN) ? ADDR_LO : ADDR_HI;

   // Next-state and counter logic; abort beats start and completion.
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      op_idx_next  = op_idx_reg;
      dir_next     = dir_reg;
      num_ops_next = num_ops_reg;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_next   = ST_RUN;
                  dir_next     = dir;
                  num_ops_next = num_ops;
                  addr_next    = (dir == DIR_DOWN) ? ADDR_HI : ADDR_LO;
                  op_idx_next  = '0;
               end
            end
            ST_RUN: begin
               if (adv) begin
                  if (op_idx_reg < num_ops_reg) begin
                     op_idx_next = op_idx_reg + OPS_WIDTH'(1);
                  end else begin
                     op_idx_next = '0;
                     if (addr_reg == end_addr) begin
                        // Address stays put: no wrap and no out-of-range code.
                        state_next = ST_DONE;
                     end else if (dir_reg == DIR_DOWN) begin
                        addr_next = addr_reg - ADDR_WIDTH'(1);
                     end else begin
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Direction-aware first/last codes for the element about to be presented.
   assign first_code = (dir_next == DIR_DOWN) ? ADDR_HI : ADDR_LO;
   assign last_code  = (dir_next == DIR_DOWN) ? ADDR_LO : ADDR_HI;

   // Next values of the registered outputs, all gated by next-busy.
   always_comb begin
      busy_next  = (state_next == ST_RUN);
      done_next  = (state_next == ST_DONE);
      first_next = busy_next && (addr_next == first_code);
      last_next  = busy_next && (addr_next == last_code);
      sel_next   = busy_next ? dec_onehot : '0;
   end

   assign busy       = busy_reg;
   assign addr       = addr_reg;
   assign sel        = sel_reg;
   assign op_idx     = op_idx_reg;
   assign first_addr = first_reg;
   assign last_addr  = last_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_arf054b128e1r1w0cbbehraa4acw_bist_addr_seq.sv
// Directed bench for the BIST address sequencer. Each test builds the expected
// per-cycle trace (plus the stimulus for that cycle) into a queue, then pops
// one entry per clock and compares against the DUT.
`timescale 1ns/1ps
module tb_arf054b128e1r1w0cbbehraa4acw_bist_addr_seq;

   logic         clk = 1'b0;
   logic         rst, start, start54, abort, dir, adv;
   logic [1:0]   num_ops;

   logic         busy, first_addr, last_addr, done;
   logic [6:0]   addr;
   logic [127:0] sel;
   logic [1:0]   op_idx;

   logic         busy54, first54, last54, done54;
   logic [5:0]   addr54;
   logic [53:0]  sel54;
   logic [1:0]   op54;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit st, ab, rs, adv;
      bit busy, first, last, done, chk_ao;
      int a, op;
   } item_t;

   item_t q[$];

   always #5 clk = ~clk;

   arf054b128e1r1w0cbbehraa4acw_bist_addr_seq #(.DEPTH(128)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
      .num_ops(num_ops), .adv(adv), .busy(busy), .addr(addr), .sel(sel),
      .op_idx(op_idx), .first_addr(first_addr), .last_addr(last_addr),
      .done(done)
   );

   arf054b128e1r1w0cbbehraa4acw_bist_addr_seq #(.DEPTH(54)) u_dut54 (
      .clk(clk), .rst(rst), .start(start54), .abort(abort), .dir(dir),
      .num_ops(num_ops), .adv(adv), .busy(busy54), .addr(addr54), .sel(sel54),
      .op_idx(op54), .first_addr(first54), .last_addr(last54),
      .done(done54)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void push(bit st, bit ab, bit rs, bit av, bit b, bit f,
                                bit l, bit d, bit chk, int a, int op);
      item_t it;
      it.st = st; it.ab = ab; it.rs = rs; it.adv = av;
      it.busy = b; it.first = f; it.last = l; it.done = d; it.chk_ao = chk;
      it.a = a; it.op = op;
      q.push_back(it);
   endfunction

   // Expected trace of one element. Negative stall/abort/reset/restart
   // arguments disable that feature.
   task automatic build(input int depth, input bit d, input int nops,
                        input int stall_addr, input int stall_len,
                        input int abort_addr, input int rst_addr,
                        input int restart_idx);
      int a;
      int idx = 0;
      for (int k = 0; k < depth; k++) begin
         a = d ? depth - 1 - k : k;
         for (int o = 0; o <= nops; o++) begin
            push(idx == 0 || idx == restart_idx, 1'b0, 1'b0, 1'b1, 1'b1,
                 k == 0, k == depth - 1, 1'b0, 1'b0, a, o);
            idx++;
            if (a == stall_addr && o == 0)
               for (int s = 0; s < stall_len; s++)
                  push(0, 0, 0, 0, 1, k == 0, k == depth - 1, 0, 0, a, o);
            if (a == abort_addr && o == nops) begin
               push(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
               push(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
               push(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
               return;
            end
            if (a == rst_addr && o == nops) begin
               push(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
               push(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
               return;
            end
         end
      end
      push(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      push(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Pops one entry per clock: drive at negedge, compare 1ns after posedge.
   task automatic run_queue(input bit which, input string tag, output int busy_cnt);
      item_t it;
      logic [3:0]   obs_ctrl, exp_ctrl;
      int           obs_a, obs_op;
      logic [127:0] exp_sel, obs_sel;
      busy_cnt = 0;
      while (q.size() > 0) begin
         it = q.pop_front();
         @(negedge clk);
         rst = it.rs; abort = it.ab; adv = it.adv;
         if (which) start54 = it.st; else start = it.st;
         @(posedge clk);
         #1;
         if (which) begin
            obs_ctrl = {busy54, first54, last54, done54};
            obs_a = int'(addr54); obs_op = int'(op54);
            obs_sel = {74'd0, sel54};
         end else begin
            obs_ctrl = {busy, first_addr, last_addr, done};
            obs_a = int'(addr); obs_op = int'(op_idx);
            obs_sel = sel;
         end
         exp_ctrl = {it.busy, it.first, it.last, it.done};
         exp_sel = '0;
         if (it.busy) exp_sel[it.a] = 1'b1;
         if (obs_ctrl[3]) busy_cnt++;
         n_checks++;
         assert (obs_ctrl === exp_ctrl) else begin
            n_errors++;
            $error("FAIL %s ctrl{busy,first,last,done}: observed %b expected %b", tag, obs_ctrl, exp_ctrl);
         end
         if (it.busy || it.chk_ao) begin
            n_checks++;
            assert (obs_a === it.a && obs_op === it.op) else begin
               n_errors++;
               $error("FAIL %s addr/op_idx: observed %0d/%0d expected %0d/%0d", tag, obs_a, obs_op, it.a, it.op);
            end
         end
         n_checks++;
         assert (obs_sel === exp_sel) else begin
            n_errors++;
            $error("FAIL %s sel: observed %h expected %h", tag, obs_sel, exp_sel);
         end
         if (which) begin
            n_checks++;
            assert (obs_a < 54) else begin
               n_errors++;
               $error("FAIL %s addr_range: observed %0d expected <54", tag, obs_a);
            end
         end
      end
      @(negedge clk);
      start = 1'b0; start54 = 1'b0; abort = 1'b0; rst = 1'b0; adv = 1'b1;
   endtask

   task automatic check_len(input string tag, input int got, input int want);
      n_checks++;
      assert (got === want) else begin
         n_errors++;
         $error("FAIL %s busy_length: observed %0d expected %0d", tag, got, want);
      end
      $display("%s: busy cycles %0d (expected %0d)", tag, got, want);
   endtask

   initial begin
      int len;
      rst = 1'b1; start = 1'b0; start54 = 1'b0; abort = 1'b0;
      dir = 1'b0; num_ops = 2'd0; adv = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      assert ({busy, first_addr, last_addr, done, addr, op_idx} === 13'd0 && sel === 128'd0) else begin
         n_errors++;
         $error("FAIL reset_state: observed busy=%b f=%b l=%b d=%b addr=%0d op=%0d sel=%h expected all zero",
                busy, first_addr, last_addr, done, addr, op_idx, sel);
      end
      n_checks++;
      assert ({busy54, first54, last54, done54, addr54, op54} === 12'd0 && sel54 === 54'd0) else begin
         n_errors++;
         $error("FAIL reset_state54: observed busy=%b addr=%0d sel=%h expected all zero", busy54, addr54, sel54);
      end
      @(negedge clk);
      rst = 1'b0;

      // Ascending, one op per address.
      dir = 1'b0; num_ops = 2'd0;
      build(128, 1'b0, 0, -1, 0, -1, -1, -1);
      run_queue(1'b0, "asc_1op", len);
      check_len("asc_1op", len, 128);

      // Descending, three ops per address.
      dir = 1'b1; num_ops = 2'd2;
      build(128, 1'b1, 2, -1, 0, -1, -1, -1);
      run_queue(1'b0, "desc_3op", len);
      check_len("desc_3op", len, 384);

      // Non-power-of-two depth.
      dir = 1'b0; num_ops = 2'd0;
      build(54, 1'b0, 0, -1, 0, -1, -1, -1);
      run_queue(1'b1, "depth54", len);
      check_len("depth54", len, 54);

      // Five stall cycles at address 40.
      build(128, 1'b0, 0, 40, 5, -1, -1, -1);
      run_queue(1'b0, "stall", len);
      check_len("stall", len, 133);

      // Abort at address 40.
      build(128, 1'b0, 0, -1, 0, 40, -1, -1);
      run_queue(1'b0, "abort", len);
      check_len("abort", len, 41);

      // Abort together with start in IDLE: stays IDLE.
      push(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      push(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      run_queue(1'b0, "abort_start", len);
      check_len("abort_start", len, 0);

      // Reset in the middle of a run.
      build(128, 1'b0, 0, -1, 0, -1, 20, -1);
      run_queue(1'b0, "midrun_rst", len);
      check_len("midrun_rst", len, 21);

      // Start while busy is ignored.
      dir = 1'b1; num_ops = 2'd1;
      build(128, 1'b1, 1, -1, 0, -1, -1, 10);
      run_queue(1'b0, "start_busy", len);
      check_len("start_busy", len, 256);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
